// File: rtl/transmit_data_if.sv
// Handshake and serial-line bundle between a frame requester and transmit_data.
// Signal suffixes are written from the transmitter's point of view.
interface transmit_data_if;
  logic        swiptAlive_i;
  logic [1:0]  program_i;
  logic        sendData_i;
  logic [35:0] txWord_i;
  logic        dout_o;
  logic        txReady_o;
  logic        busy_o;
  logic        txDone_o;
  logic [7:0]  sumOut_o;

  modport master (
    output swiptAlive_i, program_i, sendData_i, txWord_i,
    input  dout_o, txReady_o, busy_o, txDone_o, sumOut_o
  );

  modport slave (
    input  swiptAlive_i, program_i, sendData_i, txWord_i,
    output dout_o, txReady_o, busy_o, txDone_o, sumOut_o
  );
endinterface

// File: rtl/transmit_data.sv
// Serial frame transmitter: start bit, 36-bit payload MSB first, optional ones-count
// trailer (TX_CHECKSUM_TRAILER_EN), then a zero gap bit. All outputs are registered.
module transmit_data #(
  parameter int unsigned BIT_PERIOD = 200000
) (
  input  logic           clk,
  input  logic           rst,
  transmit_data_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
`ifdef TX_CHECKSUM_TRAILER_EN
  localparam logic [2:0] CSUM  = 3'd3;
`endif
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [19:0] TIMER_LOAD = 20'(BIT_PERIOD - 1);
  localparam logic [5:0]  IDX_TOP    = 6'd35;

  logic [2:0]  state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [5:0]  idx_q, idx_d;
  logic [35:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic        dout_q, dout_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef TX_CHECKSUM_TRAILER_EN
  logic [2:0]  cidx_q, cidx_d;
`endif

  logic enable_s;
  logic bit_end_s;

  assign enable_s  = bus.swiptAlive_i && (bus.program_i == 2'b11);
  assign bit_end_s = (timer_q == 20'd0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    word_d  = word_q;
    sum_d   = sum_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
`ifdef TX_CHECKSUM_TRAILER_EN
    cidx_d  = cidx_q;
`endif
    if ((state_q != IDLE) && !enable_s) begin
      // Link lost mid-frame: abandon silently, keep the partial ones count.
      state_d = IDLE;
      dout_d  = 1'b0;
      timer_d = TIMER_LOAD;
      idx_d   = IDX_TOP;
    end else begin
      case (state_q)
        IDLE: begin
          dout_d = 1'b0;
          if (enable_s && bus.sendData_i) begin
            word_d  = bus.txWord_i;
            sum_d   = 8'd0;
            timer_d = TIMER_LOAD;
            idx_d   = IDX_TOP;
            state_d = START;
            dout_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_d = DATA;
            idx_d   = IDX_TOP;
            timer_d = TIMER_LOAD;
            dout_d  = word_q[IDX_TOP];
          end else begin
            timer_d = timer_q - 20'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            sum_d   = sum_q + {7'd0, word_q[idx_q]};
            timer_d = TIMER_LOAD;
            if (idx_q == 6'd0) begin
`ifdef TX_CHECKSUM_TRAILER_EN
              state_d = CSUM;
              cidx_d  = 3'd7;
              dout_d  = sum_d[7];
`else
              state_d = GAP;
              dout_d  = 1'b0;
`endif
            end else begin
              idx_d  = idx_q - 6'd1;
              dout_d = word_q[idx_q - 6'd1];
            end
          end else begin
            timer_d = timer_q - 20'd1;
          end
        end
`ifdef TX_CHECKSUM_TRAILER_EN
        CSUM: begin
          if (bit_end_s) begin
            timer_d = TIMER_LOAD;
            if (cidx_q == 3'd0) begin
              state_d = GAP;
              dout_d  = 1'b0;
            end else begin
              cidx_d = cidx_q - 3'd1;
              dout_d = sum_q[cidx_q - 3'd1];
            end
          end else begin
            timer_d = timer_q - 20'd1;
          end
        end
`endif
        GAP: begin
          if (bit_end_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
            timer_d = TIMER_LOAD;
            idx_d   = IDX_TOP;
            dout_d  = 1'b0;
          end else begin
            timer_d = timer_q - 20'd1;
          end
        end
        default: begin
          state_d = IDLE;
          dout_d  = 1'b0;
          timer_d = TIMER_LOAD;
          idx_d   = IDX_TOP;
        end
      endcase
    end
    ready_d = (state_d == IDLE) && enable_s;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= TIMER_LOAD;
      idx_q   <= IDX_TOP;
      word_q  <= 36'd0;
      sum_q   <= 8'd0;
      dout_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_CHECKSUM_TRAILER_EN
      cidx_q  <= 3'd7;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TX_CHECKSUM_TRAILER_EN
      cidx_q  <= cidx_d;
`endif
    end
  end

  assign bus.dout_o    = dout_q;
  assign bus.txReady_o = ready_q;
  assign bus.busy_o    = busy_q;
  assign bus.txDone_o  = done_q;
  assign bus.sumOut_o  = sum_q;
endmodule

// File: tb/tb_transmit_data.sv
// Directed bench for transmit_data with BIT_PERIOD=4; frame contents follow
// TX_CHECKSUM_TRAILER_EN when the macro is defined for the whole build.
module tb_transmit_data;
  localparam int BP = 4;
`ifdef TX_CHECKSUM_TRAILER_EN
  localparam int NBITS = 46;
`else
  localparam int NBITS = 38;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  transmit_data_if bus ();
  transmit_data #(.BIT_PERIOD(BP)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ones(input logic [35:0] w);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 36; k++) s = s + {7'd0, w[k]};
    return s;
  endfunction

  // Expected line level during frame bit b (0 = start bit).
  function automatic logic exp_bit(input logic [35:0] w, input int b);
    logic [7:0] cs;
    cs = ones(w);
    if (b == 0) return 1'b1;
    if (b <= 36) return w[36 - b];
`ifdef TX_CHECKSUM_TRAILER_EN
    if (b <= 44) return cs[44 - b];
`endif
    return 1'b0;
  endfunction

  // Ones count of payload bits whose bit period has already ended during frame bit b.
  function automatic logic [7:0] exp_sum(input logic [35:0] w, input int b);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 1; k < b; k++) begin
      if (k <= 36) s = s + {7'd0, w[36 - k]};
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.dout_o !== 1'b0) begin n_fail++; $display("FAIL rst_dout got %b exp 0", bus.dout_o); end
    n_checks++; if (bus.txReady_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", bus.txReady_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
    n_checks++; if (bus.txDone_o !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.txDone_o); end
    n_checks++; if (bus.sumOut_o !== 8'd0) begin n_fail++; $display("FAIL rst_sum got %h exp 00", bus.sumOut_o); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.txReady_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b exp 1", bus.txReady_o); end
    tick();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_no_frame busy got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_frame(input logic [35:0] w);
    int b;
    bus.txWord_i = w;
    bus.sendData_i = 1'b1;
    tick();
    bus.sendData_i = 1'b0;
    bus.txWord_i = ~w;
    for (int c = 0; c < NBITS * BP; c++) begin
      b = c / BP;
      n_checks++; if (bus.dout_o !== exp_bit(w, b)) begin n_fail++; $display("FAIL frame_dout w=%h cyc %0d got %b exp %b", w, c, bus.dout_o, exp_bit(w, b)); end
      n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL frame_busy w=%h cyc %0d got %b exp 1", w, c, bus.busy_o); end
      n_checks++; if (bus.txDone_o !== 1'b0) begin n_fail++; $display("FAIL frame_early_done w=%h cyc %0d got %b exp 0", w, c, bus.txDone_o); end
      n_checks++; if (bus.sumOut_o !== exp_sum(w, b)) begin n_fail++; $display("FAIL frame_sum w=%h cyc %0d got %h exp %h", w, c, bus.sumOut_o, exp_sum(w, b)); end
      bus.sendData_i = (c == 20);
      tick();
    end
    bus.sendData_i = 1'b0;
    n_checks++; if (bus.txDone_o !== 1'b1) begin n_fail++; $display("FAIL done_pulse w=%h got %b exp 1", w, bus.txDone_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL done_busy w=%h got %b exp 0", w, bus.busy_o); end
    n_checks++; if (bus.txReady_o !== 1'b1) begin n_fail++; $display("FAIL done_ready w=%h got %b exp 1", w, bus.txReady_o); end
    n_checks++; if (bus.dout_o !== 1'b0) begin n_fail++; $display("FAIL done_dout w=%h got %b exp 0", w, bus.dout_o); end
    n_checks++; if (bus.sumOut_o !== ones(w)) begin n_fail++; $display("FAIL done_sum w=%h got %h exp %h", w, bus.sumOut_o, ones(w)); end
    tick();
    n_checks++; if (bus.txDone_o !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle w=%h got %b exp 0", w, bus.txDone_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_req_not_queued w=%h busy %b exp 0", w, bus.busy_o); end
  endtask

  task automatic test_disabled(input logic alive, input logic [1:0] prog);
    bus.swiptAlive_i = alive;
    bus.program_i = prog;
    bus.sendData_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (bus.dout_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.txDone_o !== 1'b0 || bus.txReady_o !== 1'b0)
        begin n_fail++; $display("FAIL disabled a=%b p=%b dout/busy/done/ready got %b%b%b%b exp 0000", alive, prog, bus.dout_o, bus.busy_o, bus.txDone_o, bus.txReady_o); end
    end
    bus.sendData_i = 1'b0;
    bus.swiptAlive_i = 1'b1;
    bus.program_i = 2'b11;
    tick();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL disabled_no_queue busy %b exp 0", bus.busy_o); end
  endtask

  task automatic test_abort();
    logic [35:0] w;
    w = 36'hA_5C30_F96E;
    bus.txWord_i = w;
    bus.sendData_i = 1'b1;
    tick();
    bus.sendData_i = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    bus.swiptAlive_i = 1'b0;
    tick();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy_o); end
    n_checks++; if (bus.dout_o !== 1'b0) begin n_fail++; $display("FAIL abort_dout got %b exp 0", bus.dout_o); end
    n_checks++; if (bus.txDone_o !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b exp 0", bus.txDone_o); end
    n_checks++; if (bus.sumOut_o !== exp_sum(w, 12)) begin n_fail++; $display("FAIL abort_sum got %h exp %h", bus.sumOut_o, exp_sum(w, 12)); end
    bus.swiptAlive_i = 1'b1;
    tick();
    n_checks++; if (bus.txReady_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_recover ready/busy got %b%b exp 10", bus.txReady_o, bus.busy_o); end
    test_frame(w);
  endtask

  task automatic test_reset_mid();
    bus.txWord_i = 36'hF_0F0F_0F0F;
    bus.sendData_i = 1'b1;
    tick();
    bus.sendData_i = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    rst = 1'b1;
    bus.sendData_i = 1'b1;
    tick();
    n_checks++; if (bus.dout_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.txDone_o !== 1'b0 || bus.txReady_o !== 1'b0)
      begin n_fail++; $display("FAIL midrst dout/busy/done/ready got %b%b%b%b exp 0000", bus.dout_o, bus.busy_o, bus.txDone_o, bus.txReady_o); end
    n_checks++; if (bus.sumOut_o !== 8'd0) begin n_fail++; $display("FAIL midrst_sum got %h exp 00", bus.sumOut_o); end
    bus.sendData_i = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.busy_o !== 1'b0 || bus.txReady_o !== 1'b1) begin n_fail++; $display("FAIL midrst_after busy/ready got %b%b exp 01", bus.busy_o, bus.txReady_o); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int zeros;
    bus.txWord_i = 36'h1_2345_6789;
    bus.sendData_i = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      zeros = 0;
      while (bus.txDone_o !== 1'b1 && cnt < 2 * NBITS * BP) begin
        zeros = (bus.dout_o === 1'b0) ? zeros + 1 : 0;
        tick();
        cnt++;
      end
      n_checks++; if (cnt !== NBITS * BP) begin n_fail++; $display("FAIL b2b_len frame %0d got %0d exp %0d", f, cnt, NBITS * BP); end
      n_checks++; if (zeros < BP) begin n_fail++; $display("FAIL b2b_gap frame %0d zero run %0d exp >= %0d", f, zeros, BP); end
      if (f == 1) bus.sendData_i = 1'b0;
      tick();
      if (f == 0) begin
        n_checks++; if (bus.busy_o !== 1'b1 || bus.dout_o !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy/dout got %b%b exp 11", bus.busy_o, bus.dout_o); end
      end else begin
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy got %b exp 0", bus.busy_o); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.swiptAlive_i = 1'b1;
    bus.program_i = 2'b11;
    bus.sendData_i = 1'b0;
    bus.txWord_i = 36'd0;
    test_reset();
    test_frame(36'h8_0000_0001);
    test_frame(36'hF_FFFF_FFFF);
    test_frame(36'h6_9C3A_0B17);
    test_disabled(1'b1, 2'b10);
    test_disabled(1'b0, 2'b11);
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
